// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// seg_display_ctrl : N-digit hex seven-segment controller with a frame-aligned
// shadow commit. Optional macro: DISP_LZ_BLANK_EN (leading-zero blanking).
// Revision: 1.0
// ============================================================================
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 2**24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4*NUM_DIGITS-1:0]      in_data,
  input  logic [NUM_DIGITS-1:0]        in_dp,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic                         enable,
  output logic [NUM_DIGITS-1:0][7:0]   segs_static,
  output logic [7:0]                   seg_scan,
  output logic [NUM_DIGITS-1:0]        an_scan
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_DIV_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int c_BLK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

  localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_BLK_W-1:0]    c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
  localparam logic [7:0]            c_SEG_INV  = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] c_AN_INV   = {NUM_DIGITS{ACTIVE_LOW}};

  logic                        r_pending;
  logic [4*NUM_DIGITS-1:0]     r_sh_data;
  logic [NUM_DIGITS-1:0]       r_sh_dp;
  logic                        r_act_vld;
  logic [4*NUM_DIGITS-1:0]     r_act_data;
  logic [NUM_DIGITS-1:0]       r_act_dp;
  logic [c_DIV_W-1:0]          r_div_cnt;
  logic [c_IDX_W-1:0]          r_idx;
  logic [c_BLK_W-1:0]          r_blink_cnt;
  logic                        r_blink_ph;

  logic                        w_accept;
  logic                        w_div_wrap;
  logic                        w_boundary;
  logic [NUM_DIGITS-1:0][7:0]  w_pat;
  logic [NUM_DIGITS-1:0]       w_lz;
  logic                        w_lz_run;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
      4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign in_ready   = ~r_pending & ~rst;
  assign w_accept   = in_valid & in_ready;
  assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
  assign w_boundary = w_div_wrap && (r_idx == c_IDX_LAST);

  // Accept and commit are mutually exclusive because in_ready is low while pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_act_vld  <= 1'b0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
    end else if (w_accept) begin
      r_sh_data <= in_data;
      r_sh_dp   <= in_dp;
      r_pending <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_act_data <= r_sh_data;
      r_act_dp   <= r_sh_dp;
      r_act_vld  <= 1'b1;
      r_pending  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (r_blink_cnt == c_BLK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // A digit is a leading zero only while it and every digit above it are zero
  // with no decimal point lit, so a lit dp keeps all lower digits visible.
  always_comb begin
    w_lz     = '0;
    w_lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_lz_run = w_lz_run & (r_act_data[4*k +: 4] == 4'h0) & ~r_act_dp[k];
`ifdef DISP_LZ_BLANK_EN
      w_lz[k]  = w_lz_run & (k != 0);
`endif
    end
  end

  always_comb begin
    w_pat = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!r_act_vld || !enable || (blink_mask[k] && r_blink_ph) || w_lz[k])
        w_pat[k] = 8'h00;
      else
        w_pat[k] = hex_to_seg(r_act_data[4*k +: 4]) | {7'b0, r_act_dp[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segs_static <= {NUM_DIGITS{c_SEG_INV}};
      seg_scan    <= c_SEG_INV;
      an_scan     <= c_AN_INV;
    end else begin
      segs_static <= w_pat ^ {NUM_DIGITS{c_SEG_INV}};
      seg_scan    <= w_pat[r_idx] ^ c_SEG_INV;
      an_scan     <= (NUM_DIGITS'(1) << r_idx) ^ c_AN_INV;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg_display_ctrl : randomized bench with a cycle-count reference model.
// Revision: 1.0
// ============================================================================
module tb_seg_display_ctrl;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4*N-1:0]    in_data = '0;
  logic [N-1:0]      in_dp = '0;
  logic [N-1:0]      blink_mask = '0;
  logic              enable = 1'b1;
  logic [N-1:0][7:0] segs_static;
  logic [7:0]        seg_scan;
  logic [N-1:0]      an_scan;

  seg_display_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dp       (in_dp),
    .blink_mask  (blink_mask),
    .enable      (enable),
    .segs_static (segs_static),
    .seg_scan    (seg_scan),
    .an_scan     (an_scan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time is a cycle count since reset release.
  logic [7:0]        hex_tab [16];
  int unsigned       cyc = 0;
  bit                m_pend = 1'b0;
  bit                m_vld  = 1'b0;
  logic [4*N-1:0]    m_sh_d = '0;
  logic [N-1:0]      m_sh_dp = '0;
  logic [4*N-1:0]    m_act_d = '0;
  logic [N-1:0]      m_act_dp = '0;
  logic [N-1:0][7:0] e_segs;
  logic [7:0]        e_scan;
  logic [N-1:0]      e_an;

  function automatic logic [7:0] model_pat(input int k, input bit ph);
    logic [3:0] d;
    bit lz;
    d  = m_act_d[4*k +: 4];
    lz = 1'b0;
`ifdef DISP_LZ_BLANK_EN
    lz = (k > 0) && ((m_act_d >> (4*k)) == 0) && ((m_act_dp >> k) == 0);
`endif
    if (!m_vld || !enable || (blink_mask[k] && ph) || lz) return 8'h00;
    return hex_tab[d] | {7'b0, m_act_dp[k]};
  endfunction

  task automatic model_edge();
    bit ph;
    int idx;
    bit bnd;
    if (rst) begin
      m_pend = 1'b0; m_vld = 1'b0; cyc = 0;
      e_segs = '1; e_scan = 8'hFF; e_an = '1;
    end else begin
      ph  = ((cyc / BD) % 2) == 1;
      idx = (cyc / SD) % N;
      bnd = (cyc % (SD*N)) == (SD*N - 1);
      for (int k = 0; k < N; k++) e_segs[k] = ~model_pat(k, ph);
      e_scan = ~model_pat(idx, ph);
      e_an   = ~(N'(1) << idx);
      if (bnd && m_pend) begin
        m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_vld = 1'b1; m_pend = 1'b0;
      end else if (in_valid && !m_pend) begin
        m_sh_d = in_data; m_sh_dp = in_dp; m_pend = 1'b1;
      end
      cyc++;
    end
  endtask

  task automatic tick(output bit acc);
    #1;
    chk("in_ready", in_ready, !m_pend && !rst);
    acc = in_valid && in_ready;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("segs_static", segs_static, e_segs);
    chk("seg_scan", seg_scan, e_scan);
    chk("an_scan", an_scan, e_an);
  endtask

  task automatic run(input int n);
    bit a;
    repeat (n) tick(a);
  endtask

  task automatic write_word(input logic [15:0] d, input logic [3:0] dp);
    bit acc;
    int guard;
    in_data = d; in_dp = dp; in_valid = 1'b1;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 64) begin
      tick(acc);
      guard++;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_dp    = 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hex_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    @(negedge clk);
    rst = 1'b1;
    run(2);
    chk("rst_segs", segs_static, 32'hFFFF_FFFF);
    chk("rst_an", an_scan, 4'hF);
    rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);

    write_word(16'h1234, 4'h0);
    run(40);
    chk("word_1234", segs_static, 32'h9F25_0D99);

    write_word(16'hAAAA, 4'h0);
    write_word(16'h5555, 4'h0);
    run(40);
    chk("word_5555", segs_static, 32'h4949_4949);

    write_word(16'h1234, 4'h0);
    run(20);
    blink_mask = 4'b0001;
    run(40);
    enable = 1'b0;
    run(20);
    chk("disabled", segs_static, 32'hFFFF_FFFF);
    enable = 1'b1;
    blink_mask = 4'b0000;

    write_word(16'h0007, 4'b0100);
    run(40);
`ifdef DISP_LZ_BLANK_EN
    chk("word_0007", segs_static, 32'hFF02_031F);
`else
    chk("word_0007", segs_static, 32'h0302_031F);
`endif

    rst = 1'b1; run(2); rst = 1'b0;
    run(20);
    write_word(16'hBEEF, 4'hF);
    run(1);
    rst = 1'b1; run(2); rst = 1'b0;
    run(40);
    chk("rst_drops_pending", segs_static, 32'hFFFF_FFFF);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) == 0;
      in_data  = 16'($urandom);
      in_dp    = 4'($urandom);
      if (($urandom % 50) == 0) blink_mask = 4'($urandom);
      if (($urandom % 100) == 0) enable = ($urandom % 8) != 0;
      rst = ($urandom % 400) == 0;
      run(1);
    end
    rst = 1'b0; in_valid = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
